unified_mem_arbiter: RTL and testbench

//  Shares one single-ported, variable-latency unified memory between the fetch stage (IF port) and the memory stage (DM port).

---
 rtl/unified_mem_arbiter_pkg.sv | 21 ++
 rtl/unified_mem_arbiter_starve_ctr.sv | 31 +++
 rtl/unified_mem_arbiter.sv | 130 +++++++++++++
 tb/tb_unified_mem_arbiter.sv | 579 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/unified_mem_arbiter_pkg.sv
// Shared FSM state encodings and owner codes for the unified memory arbiter.
// Imported by unified_mem_arbiter and its starvation-guard counter.
package unified_mem_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      IF_BUSY = 2'd1,
      DM_BUSY = 2'd2
   } arbState_e;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_IF   = 2'd1,
      OWN_DM   = 2'd2
   } owner_e;

   localparam int unsigned DEF_ADDR_W       = 32;
   localparam int unsigned DEF_DATA_W       = 32;
   localparam int unsigned DEF_STARVE_LIMIT = 4;

endpackage

// File: rtl/unified_mem_arbiter_starve_ctr.sv
// Saturating count of DM grants taken while a fetch was waiting.
// hit is high once the count reaches LIMIT; clr wins over inc.
module arb_starve_ctr #(
   parameter int unsigned LIMIT = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic inc,
   input  logic clr,
   output logic hit
);

   localparam int unsigned CW = $clog2(LIMIT + 1);

   logic [CW-1:0] cnt;
   logic          atLimit;

   assign atLimit = (cnt == CW'(LIMIT));
   assign hit     = atLimit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && !atLimit) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbitrates IF and DM requests onto one single-ported, variable-latency memory.
// Define ARB_STARVE_GUARD_EN to let IF win once after STARVE_LIMIT starved DM grants.
module unified_mem_arbiter
   import unified_mem_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W       = DEF_ADDR_W,
   parameter int unsigned DATA_W       = DEF_DATA_W,
   parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                if_req,
   input  logic [ADDR_W-1:0]   if_addr,
   input  logic                if_flush,
   output logic                if_ack,
   output logic [DATA_W-1:0]   if_rdata,
   output logic                if_stall,
   input  logic                dm_req,
   input  logic                dm_we,
   input  logic [ADDR_W-1:0]   dm_addr,
   input  logic [DATA_W-1:0]   dm_wdata,
   input  logic [DATA_W/8-1:0] dm_wstrb,
   output logic                dm_ack,
   output logic [DATA_W-1:0]   dm_rdata,
   output logic                dm_stall,
   output logic                mem_req,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_wstrb,
   input  logic                mem_ack,
   input  logic [DATA_W-1:0]   mem_rdata
);

   arbState_e state;
   owner_e    grant;
   logic      dropQ;
   logic      idle;
   logic      ifGo;
   logic      dmWin;
   logic      ifWin;
   logic      starveHit;

   assign idle  = (state == IDLE);
   assign ifGo  = if_req & ~if_flush;
   // The guard only overrides DM when a fetch could actually be granted.
   assign dmWin = idle & dm_req & ~(ifGo & starveHit);
   assign ifWin = idle & ifGo & ~dmWin;

`ifdef ARB_STARVE_GUARD_EN
   arb_starve_ctr #(
      .LIMIT (STARVE_LIMIT)
   ) uStarveCtr (
      .clk   (clk),
      .rst_n (reset),
      .inc   (dmWin & if_req),
      .clr   (ifWin),
      .hit   (starveHit)
   );
`else
   assign starveHit = 1'b0;
`endif

   always_comb begin
      grant = OWN_NONE;
      unique case (1'b1)
         dmWin:   grant = OWN_DM;
         ifWin:   grant = OWN_IF;
         default: grant = OWN_NONE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         dropQ     <= 1'b0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_wstrb <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               unique case (grant)
                  OWN_DM: begin
                     state     <= DM_BUSY;
                     mem_req   <= 1'b1;
                     mem_we    <= dm_we;
                     mem_addr  <= dm_addr;
                     mem_wdata <= dm_wdata;
                     mem_wstrb <= dm_wstrb;
                  end
                  OWN_IF: begin
                     state     <= IF_BUSY;
                     mem_req   <= 1'b1;
                     mem_we    <= 1'b0;
                     mem_addr  <= if_addr;
                     mem_wdata <= '0;
                     mem_wstrb <= '0;
                  end
                  default: ;
               endcase
            end
            IF_BUSY, DM_BUSY: begin
               if (mem_ack) begin
                  state   <= IDLE;
                  mem_req <= 1'b0;
                  dropQ   <= 1'b0;
               end else if ((state == IF_BUSY) && if_flush) begin
                  dropQ <= 1'b1;
               end
            end
            default: begin
               state   <= IDLE;
               mem_req <= 1'b0;
               dropQ   <= 1'b0;
            end
         endcase
      end
   end

   assign if_ack   = mem_ack & (state == IF_BUSY) & ~dropQ;
   assign dm_ack   = mem_ack & (state == DM_BUSY);
   assign if_rdata = if_ack ? mem_rdata : '0;
   assign dm_rdata = dm_ack ? mem_rdata : '0;
   assign if_stall = if_req & ~if_ack;
   assign dm_stall = dm_req & ~dm_ack;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter with an auto-responding memory model.
// Expected grant order depends on ARB_STARVE_GUARD_EN.
module tb_unified_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        if_req = 1'b0;
   logic [31:0] if_addr = '0;
   logic        if_flush = 1'b0;
   logic        if_ack;
   logic [31:0] if_rdata;
   logic        if_stall;
   logic        dm_req = 1'b0;
   logic        dm_we = 1'b0;
   logic [31:0] dm_addr = '0;
   logic [31:0] dm_wdata = '0;
   logic [3:0]  dm_wstrb = '0;
   logic        dm_ack;
   logic [31:0] dm_rdata;
   logic        dm_stall;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = '0;

   int nChecks = 0;
   int nFails = 0;

   logic        autoMem = 1'b1;
   logic        forceAck = 1'b0;
   int          memLat = 1;
   int          memCnt = 0;
   logic [31:0] memData = '0;

   unified_mem_arbiter dut (
      .clk       (clk),
      .reset     (reset),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_flush  (if_flush),
      .if_ack    (if_ack),
      .if_rdata  (if_rdata),
      .if_stall  (if_stall),
      .dm_req    (dm_req),
      .dm_we     (dm_we),
      .dm_addr   (dm_addr),
      .dm_wdata  (dm_wdata),
      .dm_wstrb  (dm_wstrb),
      .dm_ack    (dm_ack),
      .dm_rdata  (dm_rdata),
      .dm_stall  (dm_stall),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_wstrb (mem_wstrb),
      .mem_ack   (mem_ack),
      .mem_rdata (mem_rdata)
   );

   always #5 clk = ~clk;

   // Memory model: ack after memLat cycles of mem_req, one-cycle pulse.
   always @(posedge clk) begin
      #1;
      if (autoMem) begin
         if (mem_req && !mem_ack) begin
            memCnt++;
            if (memCnt >= memLat) begin
               mem_ack = 1'b1;
               mem_rdata = memData;
               memCnt = 0;
            end
         end else begin
            mem_ack = 1'b0;
            mem_rdata = '0;
         end
      end else begin
         memCnt = 0;
         mem_ack = forceAck;
         mem_rdata = forceAck ? 32'hBAD0BAD0 : 32'h0;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic test_reset();
      repeat (2) @(negedge clk);
      #1;
      nChecks++;
      if ({mem_req, mem_we, if_ack, dm_ack} !== 4'b0000) begin
         nFails++;
         $display("FAIL reset_ctrl: got %b expected 0000",
                  {mem_req, mem_we, if_ack, dm_ack});
      end
      nChecks++;
      if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
         nFails++;
         $display("FAIL reset_addr_data: got %h/%h expected 0/0",
                  mem_addr, mem_wdata);
      end
      nChecks++;
      if (mem_wstrb !== 4'h0) begin
         nFails++;
         $display("FAIL reset_wstrb: got %h expected 0", mem_wstrb);
      end
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      #1;
      nChecks++;
      if (mem_req !== 1'b0) begin
         nFails++;
         $display("FAIL idle_after_reset: mem_req got %b expected 0", mem_req);
      end
   endtask

   task automatic test_load();
      int stallCnt;
      int reqCyc;
      int ackCyc;
      logic gotAck;
      logic [31:0] ackData;
      logic [31:0] reqAddr;
      logic reqWe;
      stallCnt = 0;
      reqCyc = -1;
      ackCyc = -1;
      gotAck = 1'b0;
      ackData = '0;
      reqAddr = '0;
      reqWe = 1'b1;
      memLat = 4;
      memData = 32'hDEADBEEF;
      @(negedge clk);
      dm_req = 1'b1;
      dm_we = 1'b0;
      dm_addr = 32'h100;
      #1;
      for (int i = 0; i < 20 && !gotAck; i++) begin
         if (i > 0) begin
            @(negedge clk);
            #1;
         end
         if (mem_req && reqCyc < 0) begin
            reqCyc = i;
            reqAddr = mem_addr;
            reqWe = mem_we;
         end
         if (dm_stall) stallCnt++;
         if (dm_ack) begin
            gotAck = 1'b1;
            ackCyc = i;
            ackData = dm_rdata;
         end
      end
      @(negedge clk);
      dm_req = 1'b0;
      #1;
      nChecks++;
      if (gotAck !== 1'b1) begin
         nFails++;
         $display("FAIL load_ack_seen: got %b expected 1", gotAck);
      end
      nChecks++;
      if (ackData !== 32'hDEADBEEF) begin
         nFails++;
         $display("FAIL load_rdata: got %h expected deadbeef", ackData);
      end
      nChecks++;
      if (stallCnt != 4) begin
         nFails++;
         $display("FAIL load_stall_cycles: got %0d expected 4", stallCnt);
      end
      nChecks++;
      if (reqCyc != 1 || ackCyc != 4) begin
         nFails++;
         $display("FAIL load_latency: req %0d ack %0d expected 1 and 4",
                  reqCyc, ackCyc);
      end
      nChecks++;
      if (reqAddr !== 32'h100 || reqWe !== 1'b0) begin
         nFails++;
         $display("FAIL load_capture: addr %h we %b expected 100 0",
                  reqAddr, reqWe);
      end
      nChecks++;
      if (dm_ack !== 1'b0 || dm_rdata !== 32'h0) begin
         nFails++;
         $display("FAIL load_ack_pulse: ack %b rdata %h expected 0 0",
                  dm_ack, dm_rdata);
      end
   endtask

   task automatic test_simultaneous();
      logic        gWe[4];
      logic [31:0] gAddr[4];
      logic [3:0]  gStrb[4];
      logic [31:0] gData[4];
      int          gCyc[4];
      int          nG;
      logic        prevReq;
      logic        ifDone;
      logic        dmDone;
      logic        ifStallMid;
      nG = 0;
      prevReq = 1'b0;
      ifDone = 1'b0;
      dmDone = 1'b0;
      ifStallMid = 1'b0;
      memLat = 1;
      memData = 32'h0;
      @(negedge clk);
      if_req = 1'b1;
      if_addr = 32'h200;
      dm_req = 1'b1;
      dm_we = 1'b1;
      dm_addr = 32'h104;
      dm_wdata = 32'h55;
      dm_wstrb = 4'b0011;
      #1;
      for (int i = 0; i < 30 && !(ifDone && dmDone); i++) begin
         if (i > 0) begin
            @(negedge clk);
            if (dmDone) begin
               dm_req = 1'b0;
               dm_we = 1'b0;
               dm_wstrb = 4'b0000;
            end
            if (ifDone) if_req = 1'b0;
            #1;
         end
         if (i == 1) ifStallMid = if_stall;
         if (mem_req && !prevReq && nG < 4) begin
            gWe[nG] = mem_we;
            gAddr[nG] = mem_addr;
            gStrb[nG] = mem_wstrb;
            gData[nG] = mem_wdata;
            gCyc[nG] = i;
            nG++;
         end
         prevReq = mem_req;
         if (dm_ack) dmDone = 1'b1;
         if (if_ack) ifDone = 1'b1;
      end
      @(negedge clk);
      if_req = 1'b0;
      dm_req = 1'b0;
      dm_we = 1'b0;
      #1;
      nChecks++;
      if (nG != 2) begin
         nFails++;
         $display("FAIL simul_grant_count: got %0d expected 2", nG);
      end else begin
         nChecks++;
         if (gWe[0] !== 1'b1 || gAddr[0] !== 32'h104 ||
             gStrb[0] !== 4'b0011 || gData[0] !== 32'h55) begin
            nFails++;
            $display("FAIL simul_dm_first: we %b addr %h strb %b data %h expected 1 104 0011 55",
                     gWe[0], gAddr[0], gStrb[0], gData[0]);
         end
         nChecks++;
         if (gWe[1] !== 1'b0 || gAddr[1] !== 32'h200 || gStrb[1] !== 4'b0000) begin
            nFails++;
            $display("FAIL simul_if_second: we %b addr %h strb %b expected 0 200 0000",
                     gWe[1], gAddr[1], gStrb[1]);
         end
         nChecks++;
         if (gCyc[0] != 1 || gCyc[1] != 3) begin
            nFails++;
            $display("FAIL simul_idle_gap: cycles %0d %0d expected 1 3",
                     gCyc[0], gCyc[1]);
         end
      end
      nChecks++;
      if (ifStallMid !== 1'b1) begin
         nFails++;
         $display("FAIL simul_if_stall: got %b expected 1", ifStallMid);
      end
   endtask

   task automatic test_flush();
      logic        sawIfAck;
      logic        memAckSeen;
      int          ackCyc;
      int          reqCnt;
      logic        got;
      int          gotCyc;
      logic [31:0] gotData;
      logic [31:0] reqAddr;
      logic        reqSeen;
      sawIfAck = 1'b0;
      memAckSeen = 1'b0;
      ackCyc = -1;
      reqCnt = 0;
      memLat = 4;
      memData = 32'h13;
      @(negedge clk);
      if_req = 1'b1;
      if_flush = 1'b1;
      if_addr = 32'h2FC;
      @(negedge clk);
      #1;
      nChecks++;
      if (mem_req !== 1'b0) begin
         nFails++;
         $display("FAIL flush_idle_block: mem_req got %b expected 0", mem_req);
      end
      if_req = 1'b0;
      if_flush = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (i == 0) begin
            if_req = 1'b1;
            if_addr = 32'h300;
         end
         if (i == 2) begin
            if_flush = 1'b1;
            if_req = 1'b0;
         end
         if (i == 3) if_flush = 1'b0;
         #1;
         if (if_ack) sawIfAck = 1'b1;
         if (mem_req) reqCnt++;
         if (mem_ack && !memAckSeen) begin
            memAckSeen = 1'b1;
            ackCyc = i;
         end
      end
      nChecks++;
      if (sawIfAck !== 1'b0) begin
         nFails++;
         $display("FAIL flush_ack_suppressed: if_ack got %b expected 0", sawIfAck);
      end
      nChecks++;
      if (memAckSeen !== 1'b1 || ackCyc != 4 || reqCnt != 4) begin
         nFails++;
         $display("FAIL flush_mem_held: ack %b at %0d req cycles %0d expected 1 at 4, 4",
                  memAckSeen, ackCyc, reqCnt);
      end
      got = 1'b0;
      gotCyc = -1;
      gotData = '0;
      reqSeen = 1'b0;
      reqAddr = '0;
      memData = 32'hCAFEF00D;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (i == 0) begin
            if_req = 1'b1;
            if_addr = 32'h304;
         end
         if (got) if_req = 1'b0;
         #1;
         if (mem_req && !reqSeen) begin
            reqSeen = 1'b1;
            reqAddr = mem_addr;
         end
         if (if_ack && !got) begin
            got = 1'b1;
            gotCyc = i;
            gotData = if_rdata;
         end
      end
      if_req = 1'b0;
      nChecks++;
      if (got !== 1'b1 || gotCyc != 4) begin
         nFails++;
         $display("FAIL flush_fresh_ack: got %b at %0d expected 1 at 4", got, gotCyc);
      end
      nChecks++;
      if (gotData !== 32'hCAFEF00D || reqAddr !== 32'h304) begin
         nFails++;
         $display("FAIL flush_fresh_data: data %h addr %h expected cafef00d 304",
                  gotData, reqAddr);
      end
   endtask

   task automatic test_reset_busy();
      logic got;
      int   gotCyc;
      logic [31:0] gotData;
      autoMem = 1'b0;
      forceAck = 1'b0;
      @(negedge clk);
      dm_req = 1'b1;
      dm_we = 1'b1;
      dm_addr = 32'h180;
      dm_wdata = 32'h77;
      dm_wstrb = 4'hF;
      @(negedge clk);
      #1;
      nChecks++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h180) begin
         nFails++;
         $display("FAIL rstbusy_issue: req %b addr %h expected 1 180", mem_req, mem_addr);
      end
      #2;
      reset = 1'b0;
      #1;
      nChecks++;
      if (mem_req !== 1'b0 || mem_we !== 1'b0 ||
          mem_addr !== 32'h0 || mem_wstrb !== 4'h0) begin
         nFails++;
         $display("FAIL rstbusy_async: req %b we %b addr %h strb %h expected 0 0 0 0",
                  mem_req, mem_we, mem_addr, mem_wstrb);
      end
      @(negedge clk);
      dm_req = 1'b0;
      dm_we = 1'b0;
      dm_wstrb = 4'h0;
      reset = 1'b1;
      forceAck = 1'b1;
      @(negedge clk);
      #1;
      forceAck = 1'b0;
      nChecks++;
      if (dm_ack !== 1'b0 || if_ack !== 1'b0 || dm_rdata !== 32'h0) begin
         nFails++;
         $display("FAIL rstbusy_late_ack: dm_ack %b if_ack %b rdata %h expected 0 0 0",
                  dm_ack, if_ack, dm_rdata);
      end
      @(negedge clk);
      #1;
      nChecks++;
      if (mem_req !== 1'b0) begin
         nFails++;
         $display("FAIL rstbusy_idle: mem_req got %b expected 0", mem_req);
      end
      autoMem = 1'b1;
      memLat = 2;
      memData = 32'h1234;
      got = 1'b0;
      gotCyc = -1;
      gotData = '0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (i == 0) begin
            dm_req = 1'b1;
            dm_addr = 32'h184;
         end
         if (got) dm_req = 1'b0;
         #1;
         if (dm_ack && !got) begin
            got = 1'b1;
            gotCyc = i;
            gotData = dm_rdata;
         end
      end
      dm_req = 1'b0;
      nChecks++;
      if (got !== 1'b1 || gotCyc != 2 || gotData !== 32'h1234) begin
         nFails++;
         $display("FAIL rstbusy_recover: ack %b at %0d data %h expected 1 at 2 1234",
                  got, gotCyc, gotData);
      end
   endtask

   task automatic test_zero_strobe();
      logic got;
      int   gotCyc;
      logic reqSeen;
      logic reqWe;
      logic [3:0] reqStrb;
      got = 1'b0;
      gotCyc = -1;
      reqSeen = 1'b0;
      reqWe = 1'b0;
      reqStrb = 4'hF;
      memLat = 2;
      memData = 32'h0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (i == 0) begin
            dm_req = 1'b1;
            dm_we = 1'b1;
            dm_addr = 32'h1C0;
            dm_wdata = 32'hFF;
            dm_wstrb = 4'b0000;
         end
         if (got) begin
            dm_req = 1'b0;
            dm_we = 1'b0;
         end
         #1;
         if (mem_req && !reqSeen) begin
            reqSeen = 1'b1;
            reqWe = mem_we;
            reqStrb = mem_wstrb;
         end
         if (dm_ack && !got) begin
            got = 1'b1;
            gotCyc = i;
         end
      end
      dm_req = 1'b0;
      dm_we = 1'b0;
      nChecks++;
      if (got !== 1'b1 || gotCyc != 2) begin
         nFails++;
         $display("FAIL zstrb_ack: ack %b at %0d expected 1 at 2", got, gotCyc);
      end
      nChecks++;
      if (reqWe !== 1'b1 || reqStrb !== 4'b0000) begin
         nFails++;
         $display("FAIL zstrb_issue: we %b strb %b expected 1 0000", reqWe, reqStrb);
      end
   endtask

   task automatic test_starve();
      logic [9:0] gotSeq;
      logic [9:0] expSeq;
      int         nG;
      logic       prevReq;
      gotSeq = '0;
      nG = 0;
      prevReq = 1'b0;
`ifdef ARB_STARVE_GUARD_EN
      expSeq = 10'b10_0001_0000;
`else
      expSeq = 10'b00_0000_0000;
`endif
      memLat = 1;
      memData = 32'h0;
      @(negedge clk);
      if_req = 1'b1;
      if_addr = 32'h400;
      dm_req = 1'b1;
      dm_we = 1'b0;
      dm_addr = 32'h500;
      #1;
      for (int i = 0; i < 40 && nG < 10; i++) begin
         if (i > 0) begin
            @(negedge clk);
            #1;
         end
         if (mem_req && !prevReq) begin
            gotSeq[nG] = (mem_addr == 32'h400);
            nG++;
         end
         prevReq = mem_req;
      end
      @(negedge clk);
      if_req = 1'b0;
      dm_req = 1'b0;
      repeat (3) @(negedge clk);
      nChecks++;
      if (nG != 10) begin
         nFails++;
         $display("FAIL starve_grant_count: got %0d expected 10", nG);
      end
      nChecks++;
      if (gotSeq !== expSeq) begin
         nFails++;
         $display("FAIL starve_order: got %b expected %b (bit=1 is IF)", gotSeq, expSeq);
      end
   endtask

   initial begin
      test_reset();
      test_load();
      test_simultaneous();
      test_flush();
      test_reset_busy();
      test_zero_strobe();
      test_starve();
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
